// File: rtl/alu_rs.sv
// ALU reservation station: a compacting, age-ordered entry array in which the
// oldest entry sits in slot 0 and the oldest ready entry is offered for issue.

package alu_rs_pkg;

   typedef logic [5:0] phys_reg_tag_t;
   typedef logic [4:0] ROB_index_t;
   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 4'd0;
   localparam alu_op_t ALU_SUB = 4'd1;
   localparam alu_op_t ALU_AND = 4'd2;
   localparam alu_op_t ALU_OR  = 4'd3;
   localparam alu_op_t ALU_XOR = 4'd4;
   localparam alu_op_t ALU_SLT = 4'd5;
   localparam alu_op_t ALU_SLL = 4'd6;
   localparam alu_op_t ALU_SRL = 4'd7;
   localparam alu_op_t ALU_SRA = 4'd8;
   localparam alu_op_t ALU_LUI = 4'd9;

   typedef struct packed {
      logic          needed;
      logic          ready;
      phys_reg_tag_t tag;
   } source_t;

   typedef struct packed {
      alu_op_t       op;
      logic          itype;
      source_t       source_0;
      source_t       source_1;
      phys_reg_tag_t dest_tag;
      logic [15:0]   imm16;
      ROB_index_t    ROB_index;
   } ALU_RS_input_struct_t;

endpackage

module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 dispatch_valid,
   output logic                 dispatch_ready,
   input  ALU_RS_input_struct_t dispatch_struct,
   input  logic                 wakeup_valid,
   input  phys_reg_tag_t        wakeup_tag,
   input  logic                 kill_valid,
   input  ROB_index_t           kill_ROB_index,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output alu_op_t              issue_op,
   output logic                 issue_itype,
   output phys_reg_tag_t        issue_source_0_tag,
   output phys_reg_tag_t        issue_source_1_tag,
   output phys_reg_tag_t        issue_dest_tag,
   output logic [15:0]          issue_imm16,
   output ROB_index_t           issue_ROB_index
);

   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RS_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

   logic [RS_DEPTH-1:0]  entry_valid;
   logic [RS_DEPTH-1:0]  next_valid;
   ALU_RS_input_struct_t entry      [RS_DEPTH];
   ALU_RS_input_struct_t next_entry [RS_DEPTH];
   logic [RS_DEPTH-1:0]  issuable;
   logic [RS_DEPTH-1:0]  remove;
   logic [IDX_W-1:0]     sel;
   logic                 issue_fire;
   logic                 dispatch_accept;
   logic                 dispatch_killed;
   ALU_RS_input_struct_t dispatch_woken;
   logic [CNT_W-1:0]     wr_ptr;

   function automatic logic src_ok(input source_t s);
      return (!s.needed) || s.ready;
   endfunction

   function automatic source_t wake_src(input source_t s, input logic v,
                                        input phys_reg_tag_t t);
      source_t r;
      r = s;
      if (v && s.needed && (s.tag == t)) begin
         r.ready = 1'b1;
      end else begin
         r.ready = s.ready;
      end
      return r;
   endfunction

   function automatic ALU_RS_input_struct_t wake_entry(input ALU_RS_input_struct_t e,
                                                       input logic v,
                                                       input phys_reg_tag_t t);
      ALU_RS_input_struct_t r;
      r          = e;
      r.source_0 = wake_src(e.source_0, v, t);
      r.source_1 = wake_src(e.source_1, v, t);
      return r;
   endfunction

   // Issue eligibility uses only registered ready bits, so a wakeup or a
   // dispatch never reaches the issue port in the cycle it arrives.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         issuable[i] = entry_valid[i] && src_ok(entry[i].source_0)
                       && src_ok(entry[i].source_1);
      end
   end

   // Oldest issuable entry wins: scanning downward leaves the lowest index.
   always_comb begin
      sel = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         sel = issuable[i] ? IDX_W'(i) : sel;
      end
   end

   assign issue_valid        = |issuable;
   assign issue_op           = entry[sel].op;
   assign issue_itype        = entry[sel].itype;
   assign issue_source_0_tag = entry[sel].source_0.tag;
   assign issue_source_1_tag = entry[sel].source_1.tag;
   assign issue_dest_tag     = entry[sel].dest_tag;
   assign issue_imm16        = entry[sel].imm16;
   assign issue_ROB_index    = entry[sel].ROB_index;

   assign issue_fire      = issue_valid && issue_ready;
   // Entries are contiguous from slot 0, so the top slot being empty means count < depth.
   assign dispatch_ready  = !entry_valid[RS_DEPTH-1];
   assign dispatch_accept = dispatch_valid && dispatch_ready;
   assign dispatch_killed = kill_valid && (dispatch_struct.ROB_index == kill_ROB_index);
   assign dispatch_woken  = wake_entry(dispatch_struct, wakeup_valid, wakeup_tag);

   // An entry leaves on issue or kill; both hitting it still removes it once.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         remove[i] = entry_valid[i] &&
                     ((issue_fire && (IDX_W'(i) == sel)) ||
                      (kill_valid && (entry[i].ROB_index == kill_ROB_index)));
      end
   end

   // Compaction: survivors slide down in age order, then the new dispatch lands.
   always_comb begin
      next_valid = '0;
      wr_ptr     = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         next_entry[i] = '0;
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (entry_valid[i] && !remove[i]) begin
            next_entry[IDX_W'(wr_ptr)] = wake_entry(entry[i], wakeup_valid, wakeup_tag);
            next_valid[IDX_W'(wr_ptr)] = 1'b1;
            wr_ptr                     = wr_ptr + CNT_W'(1);
         end else begin
            wr_ptr = wr_ptr;
         end
      end
      if (dispatch_accept && !dispatch_killed && (wr_ptr < DEPTH_C)) begin
         next_entry[IDX_W'(wr_ptr)] = dispatch_woken;
         next_valid[IDX_W'(wr_ptr)] = 1'b1;
      end else begin
         wr_ptr = wr_ptr;
      end
   end

   // Entry array state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         entry_valid <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else begin
         entry_valid <= next_valid;
         for (int i = 0; i < RS_DEPTH; i++) begin
            entry[i] <= next_entry[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed cycle table, reset sequence and a
// randomized phase checked against a queue-based reference model.

module tb_alu_rs;
   import alu_rs_pkg::*;

   localparam int DEPTH = 4;

   logic                 CLK = 1'b0;
   logic                 nRST;
   logic                 dispatch_valid;
   logic                 dispatch_ready;
   ALU_RS_input_struct_t dispatch_struct;
   logic                 wakeup_valid;
   phys_reg_tag_t        wakeup_tag;
   logic                 kill_valid;
   ROB_index_t           kill_ROB_index;
   logic                 issue_valid;
   logic                 issue_ready;
   alu_op_t              issue_op;
   logic                 issue_itype;
   phys_reg_tag_t        issue_source_0_tag;
   phys_reg_tag_t        issue_source_1_tag;
   phys_reg_tag_t        issue_dest_tag;
   logic [15:0]          issue_imm16;
   ROB_index_t           issue_ROB_index;

   alu_rs #(.RS_DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRST(nRST),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_struct(dispatch_struct),
      .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
      .kill_valid(kill_valid), .kill_ROB_index(kill_ROB_index),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_itype(issue_itype),
      .issue_source_0_tag(issue_source_0_tag), .issue_source_1_tag(issue_source_1_tag),
      .issue_dest_tag(issue_dest_tag), .issue_imm16(issue_imm16),
      .issue_ROB_index(issue_ROB_index)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       dv;
      logic       s0r;
      logic [5:0] s0t;
      logic [5:0] dest;
      logic [4:0] rob;
      logic       wv;
      logic [5:0] wt;
      logic       kv;
      logic [4:0] kr;
      logic       ir;
      logic       exp_iv;
      logic [4:0] exp_rob;
      logic       exp_dr;
   } vec_t;

   vec_t                 vt[$];
   ALU_RS_input_struct_t mq[$];
   int                   errors = 0;
   int                   checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(int dv, int s0r, int s0t, int dest, int rob, int wv, int wt,
                               int kv, int kr, int ir, int eiv, int erob, int edr);
      vec_t r;
      r.dv = (dv != 0);   r.s0r = (s0r != 0); r.s0t = 6'(s0t); r.dest = 6'(dest);
      r.rob = 5'(rob);    r.wv = (wv != 0);   r.wt = 6'(wt);   r.kv = (kv != 0);
      r.kr = 5'(kr);      r.ir = (ir != 0);   r.exp_iv = (eiv != 0);
      r.exp_rob = 5'(erob); r.exp_dr = (edr != 0);
      return r;
   endfunction

   function automatic vec_t idl(int eiv, int erob, int edr);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, eiv, erob, edr);
   endfunction

   // Reference model: an age-ordered queue governed by the readiness rules.
   function automatic bit src_ok(source_t s);
      return !s.needed || s.ready;
   endfunction

   function automatic int find_sel();
      foreach (mq[i]) begin
         if (src_ok(mq[i].source_0) && src_ok(mq[i].source_1)) return i;
      end
      return -1;
   endfunction

   function automatic ALU_RS_input_struct_t wake(ALU_RS_input_struct_t e);
      ALU_RS_input_struct_t r = e;
      if (wakeup_valid && e.source_0.needed && e.source_0.tag == wakeup_tag) r.source_0.ready = 1'b1;
      if (wakeup_valid && e.source_1.needed && e.source_1.tag == wakeup_tag) r.source_1.ready = 1'b1;
      return r;
   endfunction

   task automatic check_model();
      int s;
      ALU_RS_input_struct_t e;
      s = find_sel();
      chk("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < DEPTH));
      chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
      if (s >= 0) begin
         e = mq[s];
         chk("issue_fields",
             64'({issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
                  issue_dest_tag, issue_imm16, issue_ROB_index}),
             64'({e.op, e.itype, e.source_0.tag, e.source_1.tag,
                  e.dest_tag, e.imm16, e.ROB_index}));
      end
   endtask

   task automatic advance();
      ALU_RS_input_struct_t nq[$];
      int  s;
      bit  acc;
      s   = find_sel();
      acc = dispatch_valid && (mq.size() < DEPTH);
      foreach (mq[i]) begin
         if (s == i && issue_ready) continue;
         if (kill_valid && mq[i].ROB_index == kill_ROB_index) continue;
         nq.push_back(wake(mq[i]));
      end
      if (acc && !(kill_valid && dispatch_struct.ROB_index == kill_ROB_index))
         nq.push_back(wake(dispatch_struct));
      mq = nq;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_vec(input vec_t v, input int n);
      dispatch_valid           = v.dv;
      dispatch_struct.op       = (n == 0) ? ALU_ADD : alu_op_t'(n % 10);
      dispatch_struct.itype    = 1'(n % 2);
      dispatch_struct.source_0 = '{needed: 1'b1, ready: v.s0r, tag: v.s0t};
      dispatch_struct.source_1 = '{needed: 1'b0, ready: 1'b0, tag: 6'(n)};
      dispatch_struct.dest_tag = v.dest;
      dispatch_struct.imm16    = 16'(n * 1111);
      dispatch_struct.ROB_index = v.rob;
      wakeup_valid   = v.wv;
      wakeup_tag     = v.wt;
      kill_valid     = v.kv;
      kill_ROB_index = v.kr;
      issue_ready    = v.ir;
   endtask

   task automatic drive_idle();
      dispatch_valid  = 1'b0;
      dispatch_struct = '0;
      wakeup_valid    = 1'b0;
      wakeup_tag      = '0;
      kill_valid      = 1'b0;
      kill_ROB_index  = '0;
      issue_ready     = 1'b1;
   endtask

   initial begin
      // mk(dv,s0r,s0t,dest,rob, wv,wt, kv,kr, ir, exp_iv,exp_rob,exp_dr)
      vt.push_back(mk(1,1,1,40,3, 0,0, 0,0, 1, 0,0,1));   // ADD, dest 40, ROB 3
      vt.push_back(idl(1,3,1));
      vt.push_back(idl(0,0,1));
      vt.push_back(mk(1,0,12,41,4, 0,0, 0,0, 1, 0,0,1));  // waits on tag 12
      vt.push_back(idl(0,0,1));
      vt.push_back(mk(0,0,0,0,0, 1,12, 0,0, 1, 0,0,1));
      vt.push_back(idl(1,4,1));
      vt.push_back(idl(0,0,1));
      for (int k = 0; k < 4; k++) vt.push_back(mk(1,0,20+k,42+k,5+k, 0,0, 0,0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,0,0, 1,22, 0,0, 1, 0,0,0));   // full
      vt.push_back(idl(1,7,0));
      vt.push_back(mk(0,0,0,0,0, 1,20, 0,0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,0,0, 1,21, 0,0, 1, 1,5,1));
      vt.push_back(mk(0,0,0,0,0, 1,23, 0,0, 1, 1,6,1));
      vt.push_back(idl(1,8,1));
      vt.push_back(idl(0,0,1));
      vt.push_back(mk(1,1,2,50,1, 0,0, 0,0, 0, 0,0,1));   // ROB 1,2,3 held back
      vt.push_back(mk(1,1,3,51,2, 0,0, 0,0, 0, 1,1,1));
      vt.push_back(mk(1,1,4,52,3, 0,0, 0,0, 0, 1,1,1));
      vt.push_back(idl(1,1,1));
      vt.push_back(idl(1,2,1));
      vt.push_back(idl(1,3,1));
      vt.push_back(idl(0,0,1));
      for (int k = 0; k < 3; k++) vt.push_back(mk(1,0,30+k,53+k,4+k, 0,0, 0,0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,0,0, 0,0, 1,5, 1, 0,0,1));    // kill ROB 5
      vt.push_back(mk(1,0,33,56,9, 1,33, 0,0, 1, 0,0,1)); // same-cycle wakeup
      vt.push_back(mk(0,0,0,0,0, 1,32, 0,0, 0, 1,9,1));
      vt.push_back(mk(0,0,0,0,0, 1,30, 0,0, 0, 1,6,1));
      vt.push_back(idl(1,4,1));
      vt.push_back(idl(1,6,1));
      vt.push_back(idl(1,9,1));
      vt.push_back(idl(0,0,1));
      vt.push_back(mk(1,1,5,57,10, 0,0, 0,0, 0, 0,0,1));
      vt.push_back(mk(1,1,6,58,11, 0,0, 1,10, 1, 1,10,1)); // issue+kill same entry
      vt.push_back(mk(1,0,34,59,12, 1,34, 1,12, 1, 1,11,1)); // everything at once
      vt.push_back(idl(0,0,1));

      nRST = 1'b0;
      drive_idle();
      #3;
      chk("reset_issue_valid", 64'(issue_valid), 64'(0));
      chk("reset_dispatch_ready", 64'(dispatch_ready), 64'(1));
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < vt.size(); i++) begin
         drive_vec(vt[i], i);
         @(negedge CLK);
         chk($sformatf("tbl%0d_issue_valid", i), 64'(issue_valid), 64'(vt[i].exp_iv));
         chk($sformatf("tbl%0d_dispatch_ready", i), 64'(dispatch_ready), 64'(vt[i].exp_dr));
         if (vt[i].exp_iv)
            chk($sformatf("tbl%0d_issue_rob", i), 64'(issue_ROB_index), 64'(vt[i].exp_rob));
         check_model();
         advance();
      end

      // Reset mid-stream with three ready entries waiting.
      for (int k = 0; k < 3; k++) begin
         drive_vec(mk(1,1,7+k,60+k,13+k, 0,0, 0,0, 0, 0,0,1), 100 + k);
         @(negedge CLK);
         check_model();
         advance();
      end
      drive_idle();
      issue_ready = 1'b0;
      chk("pre_reset_issue_valid", 64'(issue_valid), 64'(1));
      nRST = 1'b0;
      #1;
      chk("midreset_issue_valid", 64'(issue_valid), 64'(0));
      chk("midreset_dispatch_ready", 64'(dispatch_ready), 64'(1));
      mq.delete();
      @(posedge CLK);
      #2;
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      drive_vec(mk(1,1,9,63,16, 0,0, 0,0, 1, 0,0,1), 200);
      @(negedge CLK);
      check_model();
      advance();
      drive_idle();
      @(negedge CLK);
      chk("post_reset_first_rob", 64'(issue_ROB_index), 64'(16));
      check_model();
      advance();
      @(negedge CLK);
      chk("post_reset_no_stale", 64'(issue_valid), 64'(0));
      check_model();
      advance();

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         dispatch_valid            = ($urandom_range(0, 9) < 6);
         dispatch_struct.op        = alu_op_t'($urandom_range(0, 9));
         dispatch_struct.itype     = 1'($urandom_range(0, 1));
         dispatch_struct.source_0  = '{needed: 1'($urandom_range(0, 1)),
                                       ready: 1'($urandom_range(0, 1)),
                                       tag: 6'($urandom_range(0, 7))};
         dispatch_struct.source_1  = '{needed: 1'($urandom_range(0, 1)),
                                       ready: 1'($urandom_range(0, 1)),
                                       tag: 6'($urandom_range(0, 7))};
         dispatch_struct.dest_tag  = 6'($urandom_range(0, 63));
         dispatch_struct.imm16     = 16'($urandom);
         dispatch_struct.ROB_index = 5'($urandom_range(0, 7) + (n % 2) * 16);
         wakeup_valid   = ($urandom_range(0, 1) == 1);
         wakeup_tag     = 6'($urandom_range(0, 7));
         kill_valid     = ($urandom_range(0, 99) < 15);
         kill_ROB_index = 5'($urandom_range(0, 7) + $urandom_range(0, 1) * 16);
         issue_ready    = ($urandom_range(0, 9) < 7);
         @(negedge CLK);
         check_model();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, meaning number of reservation station entries.
REQ-002 SHALL have port CLK  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port dispatch_valid  input  1  dispatch unit presents an ALU instruction.
REQ-005 SHALL have port dispatch_ready  output  1  RS can accept a dispatch this cycle.
REQ-006 SHALL have port dispatch_struct  input  ALU_RS_input_struct_t  op, itype, source_0/1 {needed, ready, tag}, dest tag, imm16, ROB_index.
REQ-007 SHALL have port wakeup_valid  input  1  writeback broadcast of a newly ready phys reg.
REQ-008 SHALL have port wakeup_tag  input  6 (phys_reg_tag_t)  phys reg being broadcast.
REQ-009 SHALL have port kill_valid  input  1  ROB kill job this cycle.
REQ-010 SHALL have port kill_ROB_index  input  5 (ROB_index_t)  ROB index to invalidate.
REQ-011 SHALL have port issue_valid  output  1  an entry is ready to issue.
REQ-012 SHALL have port issue_ready  input  1  ALU pipeline accepts issue.
REQ-013 SHALL have ports issue_op (4), issue_itype (1), issue_source_0_tag (6), issue_source_1_tag (6), issue_dest_tag (6), issue_imm16 (16), issue_ROB_index (5), all outputs, fields of the issuing entry.

Function
REQ-014 SHALL hold entries in a compacting age-ordered array: entry 0 oldest; valid entries contiguous from 0.
REQ-015 SHALL define source operand ready as (!needed || ready); entry issuable when valid and both sources ready.
REQ-016 SHALL drive dispatch_ready = (valid count < RS_DEPTH), independent of same-cycle issue or kill.
REQ-017 SHALL accept dispatch on dispatch_valid && dispatch_ready, writing the new entry at the first free slot after same-cycle removals.
REQ-018 SHALL drive issue_valid and issue_* combinationally from the lowest-index issuable entry; issue_* don't-care when issue_valid=0.
REQ-019 SHALL remove the selected entry on issue_valid && issue_ready at the clock edge, shifting all younger entries down one slot.
REQ-020 SHALL, on wakeup_valid, set ready for every valid entry source whose tag equals wakeup_tag and needed=1; woken entry issuable no earlier than the next cycle.
REQ-021 SHALL apply a same-cycle wakeup to an accepted dispatch whose source tag matches wakeup_tag.
REQ-022 SHALL make a newly dispatched entry issuable no earlier than the cycle after acceptance (no dispatch-to-issue bypass).
REQ-023 SHALL, on kill_valid, invalidate all valid entries with ROB_index == kill_ROB_index and compact; a killed-matching dispatch in the same cycle SHALL also be dropped.
REQ-024 SHALL, when issue handshake and kill target the same entry in one cycle, complete the issue and remove the entry exactly once.
REQ-025 SHALL support dispatch, wakeup, issue, and kill all in one cycle with no lost or duplicated entries.
REQ-026 SHALL compare ROB_index on all 5 bits (including wrap bit); no ordering arithmetic.

Reset
REQ-027 SHALL, while nRST=0, clear all entry valid bits asynchronously: issue_valid=0, dispatch_ready=1.
REQ-028 SHALL discard all in-flight entries on reset mid-operation; first post-reset dispatch lands in entry 0.

Verification
REQ-029 Dispatch op=ALU_ADD, both sources needed/ready, dest=40, ROB=3; issue_ready=1 -> issue_valid=1 next cycle, issue_dest_tag=40, RS empty after.
REQ-030 Dispatch source_0 tag=12 not ready; wakeup_tag=12 two cycles later -> issue_valid=0 until cycle after wakeup, then issues.
REQ-031 Fill 4 entries, none ready -> dispatch_ready=0; issue one after wakeup -> dispatch_ready=1 following cycle.
REQ-032 Entries ROB 1,2,3 all ready, issue_ready=1 each cycle -> issue order 1,2,3.
REQ-033 Entries ROB 4,5,6; kill_ROB_index=5 -> remaining order 4,6, count 2; dispatch with wakeup_tag match same cycle -> entry ready.
REQ-034 Assert nRST=0 with 3 entries mid-stream -> issue_valid=0 immediately, dispatch_ready=1; no stale entry issues after release.
